// File: rtl/gpu_launch_pkg.sv
// Shared types and helpers for the per-core block launcher.
// Used by block_launcher and launch_mask_gen.
package gpu_launch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    DONE
  } launch_state_t;

  localparam int BLOCK_ID_W = 8;

  function automatic int tc_width(input int tpb);
    return $clog2(tpb) + 1;
  endfunction

endpackage

// File: rtl/launch_mask_gen.sv
// Lane mask and last-pass flag for one pass of a block.
// Purely combinational.
module launch_mask_gen
  import gpu_launch_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int NUM_LANES = 2,
  localparam int TCW = tc_width(THREADS_PER_BLOCK)
) (
  input  logic [TCW-1:0]       count_i,
  input  logic [TCW-1:0]       pass_index_i,
  output logic [NUM_LANES-1:0] lane_mask_o,
  output logic                 last_pass_o
);

  int rem;

  // Signed arithmetic so a pass past the end yields an empty mask.
  always_comb begin
    rem = int'(count_i) - int'(pass_index_i) * NUM_LANES;
    lane_mask_o = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_mask_o[i] = (i < rem);
    end
    last_pass_o = (rem <= NUM_LANES);
  end

endmodule

// File: rtl/block_launcher.sv
// Core-side block launcher: splits a block into NUM_LANES-wide passes.
// Optional launch-to-done cycle counter: BLOCK_LAUNCHER_PERF_EN.
module block_launcher
  import gpu_launch_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int NUM_LANES = 2,
  localparam int TCW = tc_width(THREADS_PER_BLOCK)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BLOCK_ID_W-1:0] block_id,
  input  logic [TCW-1:0]        thread_count,
  output logic                  done,
  output logic                  pipe_start,
  output logic [NUM_LANES-1:0]  lane_mask,
  output logic [BLOCK_ID_W-1:0] base_thread_id,
  output logic [TCW-1:0]        pass_index,
  input  logic                  pipe_done,
  output logic                  count_err,
  output logic [15:0]           block_cycles
);

  localparam logic [TCW-1:0] TPB = TCW'(THREADS_PER_BLOCK);

  launch_state_t state_q, state_d;
  logic [BLOCK_ID_W-1:0] bid_q, bid_d;
  logic [BLOCK_ID_W-1:0] base_q, base_d;
  logic [TCW-1:0] count_q, count_d;
  logic [TCW-1:0] pass_q, pass_d;
  logic [NUM_LANES-1:0] mask_q, mask_d;
  logic done_q, done_d;
  logic pstart_q, pstart_d;
  logic err_q, err_d;
  logic last_q, last_d;

  logic idle;
  logic over;
  logic [TCW-1:0] count_in;
  logic [TCW-1:0] gen_count;
  logic [TCW-1:0] gen_pass;
  logic [BLOCK_ID_W-1:0] gen_bid;
  logic [BLOCK_ID_W-1:0] gen_base;
  logic [NUM_LANES-1:0] gen_mask;
  logic gen_last;

  assign idle = (state_q == IDLE);
  assign over = (thread_count > TPB);
  assign count_in = over ? TPB : thread_count;

  // Describe the pass about to be launched: first pass from IDLE, else next.
  assign gen_count = idle ? count_in : count_q;
  assign gen_pass = idle ? '0 : pass_q + TCW'(1);
  assign gen_bid = idle ? block_id : bid_q;
  assign gen_base = BLOCK_ID_W'(int'(gen_bid) * THREADS_PER_BLOCK
                    + int'(gen_pass) * NUM_LANES);

  launch_mask_gen #(
    .THREADS_PER_BLOCK(THREADS_PER_BLOCK),
    .NUM_LANES(NUM_LANES)
  ) u_mask (
    .count_i(gen_count),
    .pass_index_i(gen_pass),
    .lane_mask_o(gen_mask),
    .last_pass_o(gen_last)
  );

  always_comb begin
    state_d = state_q;
    bid_d = bid_q;
    base_d = base_q;
    count_d = count_q;
    pass_d = pass_q;
    mask_d = mask_q;
    done_d = done_q;
    pstart_d = 1'b0;
    err_d = err_q;
    last_d = last_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bid_d = block_id;
          count_d = count_in;
          err_d = err_q | over;
          pass_d = '0;
          if (count_in == '0) begin
            state_d = DONE;
            done_d = 1'b1;
          end else begin
            state_d = LAUNCH;
            pstart_d = 1'b1;
            mask_d = gen_mask;
            base_d = gen_base;
            last_d = gen_last;
          end
        end
      end
      LAUNCH: state_d = RUN;
      RUN: begin
        if (pipe_done) begin
          if (last_q) begin
            state_d = DONE;
            done_d = 1'b1;
          end else begin
            state_d = LAUNCH;
            pass_d = gen_pass;
            pstart_d = 1'b1;
            mask_d = gen_mask;
            base_d = gen_base;
            last_d = gen_last;
          end
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bid_q <= '0;
      base_q <= '0;
      count_q <= '0;
      pass_q <= '0;
      mask_q <= '0;
      done_q <= 1'b0;
      pstart_q <= 1'b0;
      err_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bid_q <= bid_d;
      base_q <= base_d;
      count_q <= count_d;
      pass_q <= pass_d;
      mask_q <= mask_d;
      done_q <= done_d;
      pstart_q <= pstart_d;
      err_q <= err_d;
      last_q <= last_d;
    end
  end

  assign done = done_q;
  assign pipe_start = pstart_q;
  assign lane_mask = mask_q;
  assign base_thread_id = base_q;
  assign pass_index = pass_q;
  assign count_err = err_q;

`ifdef BLOCK_LAUNCHER_PERF_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (idle && start) begin
      cyc_d = '0;
    end else if ((state_q == LAUNCH || state_q == RUN)
                 && cyc_q != 16'hFFFF) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cyc_q <= '0;
    else cyc_q <= cyc_d;
  end

  assign block_cycles = cyc_q;
`else
  assign block_cycles = '0;
`endif

endmodule
